// File: rtl/cache_pkg.sv
// Shared types and geometry for the 2-way set-associative write-through data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Geometry: byte address = {tag, set index, 2'b byte offset}; one 32-bit word per line.
// The optional statistics counters in cache_controller are enabled by CACHE_STATS_EN.
package cache_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int INDEX_W = 6;
    localparam int TAG_W   = ADDR_W - INDEX_W - 2;
    localparam int SETS    = 1 << INDEX_W;
    localparam int WAYS    = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_t;

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: per-set valid bit, tag and data word, with a combinational hit lookup.
// Latency: lookup (hit/data) is combinational; writes land on the next posedge clk.
// Backpressure: none; the caller decides when to write.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset clears every valid bit
//   idx, tag      set index and tag being looked up (also the write target)
//   hit, data     valid & tag match for idx, and the stored word of idx
//   we, wdata     write enable and word; a write sets valid and stores tag+word
module cache_way_array
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] idx,
    input  logic [TAG_W-1:0]   tag,
    output logic               hit,
    output logic [DATA_W-1:0]  data,
    input  logic               we,
    input  logic [DATA_W-1:0]  wdata
);

    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags  [SETS];
    logic [DATA_W-1:0] words [SETS];

    assign hit  = valid[idx] && (tags[idx] == tag);
    assign data = words[idx];

    // Only valid needs clearing; tag/data contents are meaningless while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (we) begin
            valid[idx] <= 1'b1;
            tags[idx]  <= tag;
            words[idx] <= wdata;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache between MEM stage and SRAM controller.
// Latency: read hit completes in the request cycle; read miss / write complete in the cycle sram_ready is seen.
// Backpressure: ready low stalls the MEM stage; SRAM side uses read_en/write_en held until sram_ready.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset (shared with SRAM controller)
//   address, wdata                MEM-stage byte address (bits [1:0] ignored) and store data
//   MEM_R_EN, MEM_W_EN            load / store request; load wins when both are high
//   rdata, ready                  load data; request complete (low = stall)
//   sram_address, sram_wdata      passthrough of address / wdata to the SRAM controller
//   sram_read_en, sram_write_en   SRAM controller request strobes
//   sram_rdata, sram_ready        SRAM controller read data and completion
//   hit_count, miss_count         completed read hits / misses (only with CACHE_STATS_EN defined)
module cache_controller
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_read_en,
    output logic              sram_write_en,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    state_t              state;
    logic [ADDR_W-1:2]   req_addr;     // word address latched when a miss/write is accepted
    logic [DATA_W-1:0]   req_wdata;
    logic [SETS-1:0]     lru;          // 0: way0 is the next victim, 1: way1

    logic [ADDR_W-1:2]   look_addr;
    logic [INDEX_W-1:0]  set_idx;
    logic [TAG_W-1:0]    look_tag;
    logic [WAYS-1:0]     way_hit;
    logic [DATA_W-1:0]   way_data [WAYS];
    logic                hit;
    logic                victim;
    logic                fill_en;
    logic                upd_en;
    logic [WAYS-1:0]     way_we;
    logic [DATA_W-1:0]   way_wdata;
    logic                unused_addr_lsb;

    assign unused_addr_lsb = ^address[1:0];

    assign sram_address = address;
    assign sram_wdata   = wdata;

    // In IDLE the live request is looked up; once a transfer is in flight the
    // latched address is used so MEM-stage changes cannot redirect the update.
    assign look_addr = (state == IDLE) ? address[ADDR_W-1:2] : req_addr;
    assign set_idx   = look_addr[INDEX_W+1:2];
    assign look_tag  = look_addr[ADDR_W-1:INDEX_W+2];
    assign hit       = |way_hit;
    assign victim    = lru[set_idx];

    // Fill the victim on read-miss completion; on write completion refresh only a hitting way.
    assign fill_en   = (state == READ_MISS) && sram_ready;
    assign upd_en    = (state == WRITE) && sram_ready && hit;
    assign way_we[0] = (fill_en && !victim) || (upd_en && way_hit[0]);
    assign way_we[1] = (fill_en &&  victim) || (upd_en && way_hit[1]);
    assign way_wdata = fill_en ? sram_rdata : req_wdata;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way_array u_way (
            .clk   (clk),
            .rst   (rst),
            .idx   (set_idx),
            .tag   (look_tag),
            .hit   (way_hit[w]),
            .data  (way_data[w]),
            .we    (way_we[w]),
            .wdata (way_wdata)
        );
    end

    // Outputs are decoded from state plus live inputs: a read hit and the
    // SRAM completion must both be visible in the same cycle they occur.
    always_comb begin
        ready         = 1'b1;
        rdata         = '0;
        sram_read_en  = 1'b0;
        sram_write_en = 1'b0;
        case (state)
            IDLE: begin
                if (MEM_R_EN) begin
                    if (hit) begin
                        rdata = way_hit[0] ? way_data[0] : way_data[1];
                    end else begin
                        ready        = 1'b0;
                        sram_read_en = 1'b1;
                    end
                end else if (MEM_W_EN) begin
                    ready         = 1'b0;
                    sram_write_en = 1'b1;
                end
            end
            READ_MISS: begin
                ready        = sram_ready;
                // Dropped in the completion cycle so the SRAM controller does not restart.
                sram_read_en = !sram_ready;
                if (sram_ready) begin
                    rdata = sram_rdata;
                end
            end
            WRITE: begin
                ready         = sram_ready;
                sram_write_en = !sram_ready;
            end
            default: begin
                ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lru       <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MEM_R_EN) begin
                        if (hit) begin
                            lru[set_idx] <= way_hit[0];
                        end else begin
                            req_addr <= address[ADDR_W-1:2];
                            state    <= READ_MISS;
                        end
                    end else if (MEM_W_EN) begin
                        req_addr  <= address[ADDR_W-1:2];
                        req_wdata <= wdata;
                        state     <= WRITE;
                    end
                end
                READ_MISS: begin
                    if (sram_ready) begin
                        lru[set_idx] <= !victim;
                        state        <= IDLE;
                    end
                end
                WRITE: begin
                    if (sram_ready) begin
                        if (hit) begin
                            lru[set_idx] <= way_hit[0];
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if ((state == IDLE) && MEM_R_EN && hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (fill_en) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
